// File: rtl/lp_core_tracker.sv
// rtl/lp_core_tracker.sv - per-core LP occupancy, stall/release and minimum-timestamp tracker
module lp_core_tracker #(
  parameter int NUM_CORE = 4,
  parameter int NUM_LP   = 8,
  parameter int TIME_WID = 16,
  parameter int HIST_WID = 4,
  parameter int MSG_WID  = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [MSG_WID-1:0]           send_msg,
  input  logic                         send_vld,
  input  logic [$clog2(NUM_CORE)-1:0]  send_core,
  input  logic [MSG_WID-1:0]           rcv_msg,
  input  logic                         rcv_vld,
  input  logic [$clog2(NUM_CORE)-1:0]  rcv_core,
  output logic [NUM_CORE-1:0]          stall,
  output logic [NUM_CORE-1:0]          core_active,
  output logic [HIST_WID*NUM_CORE-1:0] core_hist_cnt,
  output logic [TIME_WID-1:0]          min_time,
  output logic                         min_time_vld,
  output logic [$clog2(NUM_CORE):0]    active_cnt,
  output logic                         protocol_err
);
  localparam int CW  = $clog2(NUM_CORE);
  localparam int LW  = $clog2(NUM_LP);
  localparam int NLP = 1 << LW;

  logic [LW-1:0]       lp_q    [NUM_CORE];
  logic [TIME_WID-1:0] time_q  [NUM_CORE];
  logic [HIST_WID-1:0] hist_q  [NUM_CORE];
  logic [HIST_WID-1:0] lp_hist [NLP];

  logic [LW-1:0]       lp_n    [NUM_CORE];
  logic [TIME_WID-1:0] time_n  [NUM_CORE];
  logic [HIST_WID-1:0] hist_n  [NUM_CORE];
  logic [NUM_CORE-1:0] act_n, stall_n;
  logic [TIME_WID-1:0] mt_n, best_time;
  logic                mv_n, rcv_ok, send_ok, err_n, rel_found, snd_stall;
  logic [CW-1:0]       rel_idx;
  logic [CW:0]         cnt_n;

  wire [TIME_WID-1:0] send_time = send_msg[TIME_WID-1:0];
  wire [LW-1:0]       send_lp   = send_msg[TIME_WID +: LW];
  wire [HIST_WID-1:0] rcv_hist  = rcv_msg[MSG_WID-1 -: HIST_WID];
  wire [LW-1:0]       rcv_lp    = lp_q[rcv_core];
  wire                unused_msg_bits = ^{send_msg, rcv_msg};

  always_comb begin
    act_n     = core_active;
    stall_n   = stall;
    lp_n      = lp_q;
    time_n    = time_q;
    hist_n    = hist_q;
    rel_found = 1'b0;
    rel_idx   = '0;
    best_time = '0;
    snd_stall = 1'b0;
    mt_n      = '0;
    mv_n      = 1'b0;
    cnt_n     = '0;

    rcv_ok = rcv_vld && core_active[rcv_core];
    // Release candidates come from the registered stall vector, so a core sent this cycle never qualifies.
    for (int p = 0; p < NUM_CORE; p++) begin
      if (rcv_ok && CW'(p) != rcv_core && core_active[p] && stall[p] && lp_q[p] == rcv_lp &&
          (!rel_found || time_q[p] < best_time)) begin
        rel_found = 1'b1;
        rel_idx   = CW'(p);
        best_time = time_q[p];
      end
    end
    if (rcv_ok) begin
      act_n[rcv_core]   = 1'b0;
      stall_n[rcv_core] = 1'b0;
    end
    if (rel_found) begin
      stall_n[rel_idx] = 1'b0;
      hist_n[rel_idx]  = rcv_hist;
    end

    send_ok = send_vld && !act_n[send_core];
    for (int p = 0; p < NUM_CORE; p++) begin
      if (CW'(p) != send_core && act_n[p] && lp_q[p] == send_lp) snd_stall = 1'b1;
    end
    if (send_ok) begin
      act_n[send_core]   = 1'b1;
      stall_n[send_core] = snd_stall;
      lp_n[send_core]    = send_lp;
      time_n[send_core]  = send_time;
      hist_n[send_core]  = (rcv_ok && rcv_lp == send_lp) ? rcv_hist : lp_hist[send_lp];
    end

    err_n = protocol_err || (rcv_vld && !rcv_ok) || (send_vld && !send_ok);

    for (int p = 0; p < NUM_CORE; p++) begin
      if (act_n[p] && (!mv_n || time_n[p] < mt_n)) begin
        mv_n = 1'b1;
        mt_n = time_n[p];
      end
      cnt_n = cnt_n + {{CW{1'b0}}, act_n[p]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_active  <= '0;
      stall        <= '0;
      min_time     <= '0;
      min_time_vld <= 1'b0;
      active_cnt   <= '0;
      protocol_err <= 1'b0;
      for (int p = 0; p < NUM_CORE; p++) begin
        lp_q[p]   <= '0;
        time_q[p] <= '0;
        hist_q[p] <= '0;
      end
      for (int l = 0; l < NLP; l++) lp_hist[l] <= '0;
    end else begin
      core_active  <= act_n;
      stall        <= stall_n;
      min_time     <= mt_n;
      min_time_vld <= mv_n;
      active_cnt   <= cnt_n;
      protocol_err <= err_n;
      lp_q         <= lp_n;
      time_q       <= time_n;
      hist_q       <= hist_n;
      if (rcv_ok) lp_hist[rcv_lp] <= rcv_hist;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_CORE; p++) core_hist_cnt[p*HIST_WID +: HIST_WID] = hist_q[p];
  end
endmodule

// File: tb/tb_lp_core_tracker.sv
// tb/tb_lp_core_tracker.sv - scoreboard bench for lp_core_tracker against a behavioural model
module tb_lp_core_tracker;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] send_msg = '0, rcv_msg = '0;
  logic        send_vld = 1'b0, rcv_vld = 1'b0;
  logic [1:0]  send_core = '0, rcv_core = '0;
  logic [3:0]  stall, core_active;
  logic [15:0] core_hist_cnt, min_time;
  logic        min_time_vld, protocol_err;
  logic [2:0]  active_cnt;

  lp_core_tracker dut (
    .clk(clk), .reset_n(reset_n),
    .send_msg(send_msg), .send_vld(send_vld), .send_core(send_core),
    .rcv_msg(rcv_msg), .rcv_vld(rcv_vld), .rcv_core(rcv_core),
    .stall(stall), .core_active(core_active), .core_hist_cnt(core_hist_cnt),
    .min_time(min_time), .min_time_vld(min_time_vld),
    .active_cnt(active_cnt), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  stall;
    logic [3:0]  act;
    logic [15:0] hist;
    logic [15:0] mt;
    logic        mv;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_g;
  int   vectors = 0, miscompares = 0, cyc = 0;

  // Model state: what each core is doing and the last history seen per LP.
  bit m_act[NC], m_stall[NC], m_err;
  int m_lp[NC], m_time[NC], m_hist[NC], m_lph[8];

  function automatic logic [31:0] mk(input int lp, input int t, input int h);
    logic [31:0] m;
    m = '0;
    m[15:0]  = t[15:0];
    m[18:16] = lp[2:0];
    m[31:28] = h[3:0];
    return m;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    foreach (m_act[p]) begin
      e.act[p]         = m_act[p];
      e.stall[p]       = m_stall[p];
      e.hist[p*4 +: 4] = m_hist[p][3:0];
      if (m_act[p]) begin
        if (!e.mv || m_time[p] < int'(e.mt)) e.mt = m_time[p][15:0];
        e.mv  = 1'b1;
        e.cnt = e.cnt + 3'd1;
      end
    end
    e.err = m_err;
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit sv, input int sc, input int slp, input int st,
                            input int sh, input bit rv, input int rc, input int rh);
    int best;
    bit waiting;
    if (rst) begin
      foreach (m_act[p]) begin
        m_act[p] = 0; m_stall[p] = 0; m_lp[p] = 0; m_time[p] = 0; m_hist[p] = 0;
      end
      foreach (m_lph[l]) m_lph[l] = 0;
      m_err = 0;
      return;
    end
    if (rv) begin
      if (!m_act[rc]) m_err = 1;
      else begin
        m_lph[m_lp[rc]] = rh;
        best = -1;
        foreach (m_act[p])
          if (p != rc && m_act[p] && m_stall[p] && m_lp[p] == m_lp[rc])
            if (best < 0 || m_time[p] < m_time[best]) best = p;
        m_act[rc] = 0;
        m_stall[rc] = 0;
        if (best >= 0) begin
          m_stall[best] = 0;
          m_hist[best]  = rh;
        end
      end
    end
    if (sv) begin
      if (m_act[sc]) m_err = 1;
      else begin
        waiting = 0;
        foreach (m_act[p]) if (p != sc && m_act[p] && m_lp[p] == slp) waiting = 1;
        m_act[sc] = 1; m_stall[sc] = waiting;
        m_lp[sc] = slp; m_time[sc] = st; m_hist[sc] = m_lph[slp];
      end
    end
  endtask

  task automatic step(input bit rst, input bit sv, input int sc, input int slp, input int st,
                      input int sh, input bit rv, input int rc, input int rh);
    @(negedge clk);
    reset_n   = !rst;
    send_vld  = sv;
    send_core = sc[1:0];
    send_msg  = mk(slp, st, sh);
    rcv_vld   = rv;
    rcv_core  = rc[1:0];
    // LP and time fields of a return are junk: the tracker must use its own record of the core.
    rcv_msg   = mk($urandom_range(0, 7), $urandom, rh);
    model_step(rst, sv, sc, slp, st, sh, rv, rc, rh);
    exp_q.push_back(model_out());
  endtask

  task automatic snd(input int c, input int lp, input int t);
    step(0, 1, c, lp, t, $urandom_range(0, 15), 0, 0, 0);
  endtask

  task automatic rcv(input int c, input int h);
    step(0, 0, 0, 0, 0, 0, 1, c, h);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cycle();
    step(1, $urandom_range(0, 1), $urandom_range(0, 3), 1, 1, 1, $urandom_range(0, 1), $urandom_range(0, 3), 9);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_g = {stall, core_active, core_hist_cnt, min_time, min_time_vld, active_cnt, protocol_err};
        vectors++;
        if (mon_g !== mon_e) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got stall=%b act=%b hist=%h mt=%0d mv=%b cnt=%0d err=%b, expected stall=%b act=%b hist=%h mt=%0d mv=%b cnt=%0d err=%b",
                   cyc, mon_g.stall, mon_g.act, mon_g.hist, mon_g.mt, mon_g.mv, mon_g.cnt, mon_g.err,
                   mon_e.stall, mon_e.act, mon_e.hist, mon_e.mt, mon_e.mv, mon_e.cnt, mon_e.err);
        end
      end
    end
  end

  initial begin
    int sc, rc, idle_q[$], busy_q[$];
    bit sv, rv;
    rst_cycle(); rst_cycle();

    // Two cores on one LP: the later one waits.
    snd(0, 3, 10); snd(1, 3, 5); idle();
    rst_cycle();

    // Release picks the smallest time, lowest index on a tie.
    snd(1, 2, 9); snd(2, 2, 4); snd(3, 2, 4); rcv(1, 7); idle();
    snd(1, 2, 20); idle();
    rst_cycle();

    // Same-cycle receive/send on one LP sees the fresh history.
    snd(0, 5, 30); step(0, 1, 1, 5, 40, 0, 1, 0, 3); idle();
    rst_cycle();

    // Same-cycle release and send: the waiter runs, the newcomer waits.
    snd(0, 1, 8); snd(2, 1, 6); step(0, 1, 3, 1, 2, 0, 1, 0, 11); idle();
    rst_cycle();

    // Protocol errors leave state alone and stick until reset.
    snd(2, 4, 100); snd(2, 6, 1); rcv(1, 5); idle(); idle();
    rst_cycle(); idle();

    // Send and receive the same core in one cycle.
    snd(1, 0, 0); step(0, 1, 1, 0, 65535, 0, 1, 1, 12); idle();

    // Everything busy, then reset mid-traffic.
    snd(0, 2, 50); snd(2, 2, 7); snd(3, 6, 65535);
    step(1, 1, 0, 3, 3, 3, 1, 1, 4); idle();

    for (int i = 0; i < 3000; i++) begin
      idle_q = {}; busy_q = {};
      foreach (m_act[p]) if (m_act[p]) busy_q.push_back(p); else idle_q.push_back(p);
      sv = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 45);
      sc = $urandom_range(0, 3);
      rc = $urandom_range(0, 3);
      if (idle_q.size() > 0 && $urandom_range(0, 99) < 90) sc = idle_q[$urandom_range(0, idle_q.size() - 1)];
      if (busy_q.size() > 0 && $urandom_range(0, 99) < 90) rc = busy_q[$urandom_range(0, busy_q.size() - 1)];
      if ($urandom_range(0, 199) == 0) rst_cycle();
      else step(0, sv, sc, $urandom_range(0, 3), $urandom_range(0, 31), 0, rv, rc, $urandom_range(0, 15));
    end

    idle(); idle();
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
